// File: rtl/bpu_bht_pkg.sv
// Shared types for the branch history/target table.
// Entry and verify-result layouts, branch types and counter helpers.
package bpu_bht_pkg;

    localparam int BHT_INDEX_W = 8;
    localparam int BHT_TAG_W   = 22;
    localparam int BHT_CNT_W   = 2;

    typedef logic [31:0] virt_t;

    typedef enum logic [1:0] {
        BR_COND = 2'd0,
        BR_JUMP = 2'd1,
        BR_CALL = 2'd2,
        BR_RET  = 2'd3
    } branch_type_t;

    typedef struct packed {
        logic [BHT_TAG_W-1:0] tag;
        branch_type_t         br_type;
        logic [BHT_CNT_W-1:0] count;
        virt_t                target;
    } BHT_entry_t;

    typedef struct packed {
        logic       valid;
        logic       success;
        BHT_entry_t verify_entry;
        logic       taken;
        virt_t      target;
        virt_t      pc;
    } verify_result_t;

    function automatic logic [BHT_CNT_W-1:0] sat_inc(
        input logic [BHT_CNT_W-1:0] c
    );
        return (&c) ? c : c + BHT_CNT_W'(1);
    endfunction

    function automatic logic [BHT_CNT_W-1:0] sat_dec(
        input logic [BHT_CNT_W-1:0] c
    );
        return (|c) ? c - BHT_CNT_W'(1) : c;
    endfunction

endpackage

// File: rtl/bpu_bht_ram.sv
// Tag/type/count/target storage for the BHT.
// Two synchronous read ports (lookup, update) and one write port.
module bpu_bht_ram
    import bpu_bht_pkg::*;
#(
    parameter int INDEX_W = 8
) (
    input  logic               clk,
    input  logic               i_rd0_en,
    input  logic [INDEX_W-1:0] i_rd0_idx,
    output BHT_entry_t         o_rd0_data,
    input  logic               i_rd1_en,
    input  logic [INDEX_W-1:0] i_rd1_idx,
    output BHT_entry_t         o_rd1_data,
    input  logic               i_we,
    input  logic [INDEX_W-1:0] i_wr_idx,
    input  BHT_entry_t         i_wr_data
);

    BHT_entry_t r_mem [2**INDEX_W];
    BHT_entry_t r_rd0;
    BHT_entry_t r_rd1;

    // Read ports hold their last data when not enabled; reads see pre-write data.
    always_ff @(posedge clk) begin
        if (i_rd0_en) r_rd0 <= r_mem[i_rd0_idx];
        if (i_rd1_en) r_rd1 <= r_mem[i_rd1_idx];
        if (i_we)     r_mem[i_wr_idx] <= i_wr_data;
    end

    assign o_rd0_data = r_rd0;
    assign o_rd1_data = r_rd1;

endmodule

// File: rtl/bpu_bht.sv
// Branch history/target table: 1-cycle lookup, 2-stage update RMW.
// Optional BPU_PERF_CNT_EN adds lookup/mispredict counters.
module bpu_bht
    import bpu_bht_pkg::*;
#(
    parameter int                   INDEX_W  = BHT_INDEX_W,
    parameter int                   TAG_W    = BHT_TAG_W,
    parameter logic [BHT_CNT_W-1:0] CNT_INIT = 2'b10
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           flush,
    input  logic           lookup_en,
    input  logic           lookup_valid,
    input  virt_t          lookup_pc,
    output logic           pred_valid,
    output logic           pred_hit,
    output logic           pred_taken,
    output BHT_entry_t     pred_entry,
    input  logic           update_valid,
    input  verify_result_t update_result,
    output logic [31:0]    perf_lookup_cnt,
    output logic [31:0]    perf_miss_cnt
);

    localparam int DEPTH = 2**INDEX_W;

    logic [DEPTH-1:0]   r_valid;
    logic               r_pred_valid;
    logic               r_lk_seen;
    logic               r_lk_vbit;
    virt_t              r_lk_pc;
    logic               r_u1_v;
    virt_t              r_u1_pc;
    logic               r_u1_taken;
    virt_t              r_u1_target;
    branch_type_t       r_u1_type;
    logic               r_u1_vbit;
    logic               r_u1_fwd;
    BHT_entry_t         r_u1_fwd_entry;

    logic               w_lk_acc;
    logic [INDEX_W-1:0] w_lk_idx;
    BHT_entry_t         w_lk_rdata;
    logic               w_lk_hit;
    BHT_entry_t         w_miss_entry;
    logic               w_u1_acc;
    logic [INDEX_W-1:0] w_up_idx;
    logic               w_fwd;
    BHT_entry_t         w_u1_rdata;
    BHT_entry_t         w_u1_entry;
    logic [INDEX_W-1:0] w_u2_idx;
    logic [TAG_W-1:0]   w_u2_tag;
    logic               w_u2_hit;
    logic               w_u2_we;
    BHT_entry_t         w_u2_wdata;
    logic               w_unused_ok;

    assign w_lk_acc = lookup_en && lookup_valid && !flush;
    assign w_lk_idx = lookup_pc[INDEX_W+1:2];
    assign w_u1_acc = update_valid && update_result.valid;
    assign w_up_idx = update_result.pc[INDEX_W+1:2];
    assign w_fwd    = w_u2_we && (w_u2_idx == w_up_idx);

    bpu_bht_ram #(.INDEX_W(INDEX_W)) u_ram (
        .clk        (clk),
        .i_rd0_en   (w_lk_acc),
        .i_rd0_idx  (w_lk_idx),
        .o_rd0_data (w_lk_rdata),
        .i_rd1_en   (w_u1_acc),
        .i_rd1_idx  (w_up_idx),
        .o_rd1_data (w_u1_rdata),
        .i_we       (w_u2_we),
        .i_wr_idx   (w_u2_idx),
        .i_wr_data  (w_u2_wdata)
    );

    // Lookup response state; lookup_en low freezes everything but flush.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pred_valid <= 1'b0;
            r_lk_seen    <= 1'b0;
            r_lk_vbit    <= 1'b0;
            r_lk_pc      <= '0;
        end else begin
            if (flush)          r_pred_valid <= 1'b0;
            else if (lookup_en) r_pred_valid <= lookup_valid;
            if (w_lk_acc) begin
                r_lk_seen <= 1'b1;
                r_lk_vbit <= r_valid[w_lk_idx];
                r_lk_pc   <= lookup_pc;
            end
        end
    end

    assign w_lk_hit = r_lk_seen && r_lk_vbit &&
                      (w_lk_rdata.tag == r_lk_pc[31:32-TAG_W]);

    // Miss prediction: fall through to the next fetch pair, weakly not-taken.
    always_comb begin
        w_miss_entry        = '0;
        w_miss_entry.tag    = r_lk_pc[31:32-TAG_W];
        w_miss_entry.count  = BHT_CNT_W'(1);
        w_miss_entry.target = r_lk_pc + 32'd8;
    end

    // Response mux: all-zero until the first lookup after reset.
    always_comb begin
        pred_entry = '0;
        if (w_lk_hit)       pred_entry = w_lk_rdata;
        else if (r_lk_seen) pred_entry = w_miss_entry;
    end

    assign pred_valid = r_pred_valid;
    assign pred_hit   = w_lk_hit;
    assign pred_taken = w_lk_hit && w_lk_rdata.count[1];

    // U1: latch the resolved branch; forward a same-index U2 write.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_u1_v         <= 1'b0;
            r_u1_pc        <= '0;
            r_u1_taken     <= 1'b0;
            r_u1_target    <= '0;
            r_u1_type      <= BR_COND;
            r_u1_vbit      <= 1'b0;
            r_u1_fwd       <= 1'b0;
            r_u1_fwd_entry <= '0;
        end else begin
            r_u1_v <= w_u1_acc;
            if (w_u1_acc) begin
                r_u1_pc        <= update_result.pc;
                r_u1_taken     <= update_result.taken;
                r_u1_target    <= update_result.target;
                r_u1_type      <= update_result.verify_entry.br_type;
                r_u1_vbit      <= r_valid[w_up_idx] | w_fwd;
                r_u1_fwd       <= w_fwd;
                r_u1_fwd_entry <= w_u2_wdata;
            end
        end
    end

    assign w_u1_entry = r_u1_fwd ? r_u1_fwd_entry : w_u1_rdata;
    assign w_u2_idx   = r_u1_pc[INDEX_W+1:2];
    assign w_u2_tag   = r_u1_pc[31:32-TAG_W];
    assign w_u2_hit   = r_u1_vbit && (w_u1_entry.tag == w_u2_tag);

    // U2: train the counter, or allocate on a taken miss.
    always_comb begin
        w_u2_we        = 1'b0;
        w_u2_wdata     = w_u1_entry;
        w_u2_wdata.tag = w_u2_tag;
        unique case (1'b1)
            (w_u2_hit && r_u1_taken): begin
                w_u2_we            = r_u1_v;
                w_u2_wdata.count   = sat_inc(w_u1_entry.count);
                w_u2_wdata.target  = r_u1_target;
                w_u2_wdata.br_type = r_u1_type;
            end
            (w_u2_hit && !r_u1_taken): begin
                w_u2_we          = r_u1_v;
                w_u2_wdata.count = sat_dec(w_u1_entry.count);
            end
            (!w_u2_hit && r_u1_taken): begin
                w_u2_we            = r_u1_v;
                w_u2_wdata.count   = CNT_INIT;
                w_u2_wdata.target  = r_u1_target;
                w_u2_wdata.br_type = r_u1_type;
            end
            default: ;
        endcase
    end

    // Valid bits only ever get set by a U2 write; reset clears them all.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)      r_valid <= '0;
        else if (w_u2_we) r_valid[w_u2_idx] <= 1'b1;
    end

`ifdef BPU_PERF_CNT_EN
    logic [31:0] r_perf_lookup;
    logic [31:0] r_perf_miss;

    // Free-running event counters, wrapping at 2**32.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_perf_lookup <= '0;
            r_perf_miss   <= '0;
        end else begin
            if (w_lk_acc)
                r_perf_lookup <= r_perf_lookup + 32'd1;
            if (w_u1_acc && !update_result.success)
                r_perf_miss <= r_perf_miss + 32'd1;
        end
    end

    assign perf_lookup_cnt = r_perf_lookup;
    assign perf_miss_cnt   = r_perf_miss;
`else
    assign perf_lookup_cnt = 32'b0;
    assign perf_miss_cnt   = 32'b0;
`endif

    assign w_unused_ok = ^{update_result.success,
                           update_result.verify_entry.tag,
                           update_result.verify_entry.count,
                           update_result.verify_entry.target,
                           r_u1_pc[1:0]};

endmodule

// File: tb/tb_bpu_bht.sv
// Testbench for bpu_bht: scoreboard of expected lookup responses
// plus per-scenario inline checks (reset, hazards, hold, flush).
module tb_bpu_bht;
    import bpu_bht_pkg::*;

    logic           clk = 1'b0;
    logic           resetn;
    logic           flush;
    logic           lookup_en;
    logic           lookup_valid;
    virt_t          lookup_pc;
    logic           pred_valid;
    logic           pred_hit;
    logic           pred_taken;
    BHT_entry_t     pred_entry;
    logic           update_valid;
    verify_result_t update_result;
    logic [31:0]    perf_lookup_cnt;
    logic [31:0]    perf_miss_cnt;

    typedef struct {
        logic        hit;
        logic        taken;
        logic [1:0]  cnt;
        logic [31:0] tgt;
        logic [1:0]  ty;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   n_look = 0;
    int   n_miss = 0;
    logic m_acc;
    exp_t m_e;

    bpu_bht dut (
        .clk             (clk),
        .resetn          (resetn),
        .flush           (flush),
        .lookup_en       (lookup_en),
        .lookup_valid    (lookup_valid),
        .lookup_pc       (lookup_pc),
        .pred_valid      (pred_valid),
        .pred_hit        (pred_hit),
        .pred_taken      (pred_taken),
        .pred_entry      (pred_entry),
        .update_valid    (update_valid),
        .update_result   (update_result),
        .perf_lookup_cnt (perf_lookup_cnt),
        .perf_miss_cnt   (perf_miss_cnt)
    );

    always #5 clk = ~clk;

    // Response monitor: every accepted lookup pops one expectation.
    always @(posedge clk) begin
        m_acc = resetn && lookup_en && lookup_valid && !flush;
        #1;
        if (m_acc) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL pred_unexpected: response with empty scoreboard");
            end else begin
                m_e = sb.pop_front();
                if (pred_valid !== 1'b1 || pred_hit !== m_e.hit ||
                    pred_taken !== m_e.taken || pred_entry.count !== m_e.cnt ||
                    pred_entry.target !== m_e.tgt || pred_entry.br_type !== m_e.ty) begin
                    errors++;
                    $display("FAIL pred: got v=%0b hit=%0b tk=%0b cnt=%b tgt=%h ty=%0d exp hit=%0b tk=%0b cnt=%b tgt=%h ty=%0d",
                             pred_valid, pred_hit, pred_taken, pred_entry.count,
                             pred_entry.target, pred_entry.br_type,
                             m_e.hit, m_e.taken, m_e.cnt, m_e.tgt, m_e.ty);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic lookup(input virt_t pc, input logic hit,
                          input logic [1:0] cnt, input virt_t tgt);
        exp_t e;
        lookup_en    = 1'b1;
        lookup_valid = 1'b1;
        lookup_pc    = pc;
        e.hit   = hit;
        e.taken = hit && cnt[1];
        e.cnt   = hit ? cnt : 2'b01;
        e.tgt   = hit ? tgt : pc + 32'd8;
        e.ty    = hit ? 2'd2 : 2'd0;
        sb.push_back(e);
        n_look++;
        @(posedge clk); #1;
        lookup_valid = 1'b0;
    endtask

    task automatic upd(input virt_t pc, input virt_t tgt,
                       input logic taken, input logic success);
        update_valid                       = 1'b1;
        update_result                      = '0;
        update_result.valid                = 1'b1;
        update_result.success              = success;
        update_result.verify_entry.br_type = BR_CALL;
        update_result.taken                = taken;
        update_result.target               = tgt;
        update_result.pc                   = pc;
        if (!success) n_miss++;
        @(posedge clk); #1;
        update_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (pred_valid !== 1'b0 || pred_hit !== 1'b0 || pred_taken !== 1'b0 ||
            pred_entry !== '0) begin
            errors++;
            $display("FAIL reset_pred: v=%0b hit=%0b tk=%0b entry=%h, want all 0",
                     pred_valid, pred_hit, pred_taken, pred_entry);
        end
        checks++;
        if (perf_lookup_cnt !== 32'd0 || perf_miss_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_perf: lookup=%0d miss=%0d, want 0 0",
                     perf_lookup_cnt, perf_miss_cnt);
        end
        resetn = 1'b1;
        idle(1);
    endtask

    task automatic test_miss;
        lookup(32'hBFC00010, 1'b0, 2'b00, 32'h0);
        idle(1);
    endtask

    task automatic test_update_taken;
        upd(32'hBFC00010, 32'hBFC00100, 1'b1, 1'b0);
        lookup(32'hBFC00010, 1'b0, 2'b00, 32'h0);
        lookup(32'hBFC00010, 1'b1, 2'b10, 32'hBFC00100);
    endtask

    task automatic test_saturation;
        upd(32'hBFC00010, 32'hBFC00100, 1'b1, 1'b1);
        idle(1);
        upd(32'hBFC00010, 32'hBFC00100, 1'b1, 1'b1);
        idle(1);
        lookup(32'hBFC00010, 1'b1, 2'b11, 32'hBFC00100);
        upd(32'hBFC00010, 32'hDEAD0000, 1'b0, 1'b0);
        idle(1);
        lookup(32'hBFC00010, 1'b1, 2'b10, 32'hBFC00100);
        upd(32'hBFC00010, 32'hDEAD0000, 1'b0, 1'b0);
        idle(1);
        upd(32'hBFC00010, 32'hDEAD0000, 1'b0, 1'b0);
        idle(1);
        lookup(32'hBFC00010, 1'b1, 2'b00, 32'hBFC00100);
        upd(32'hBFC00010, 32'hDEAD0000, 1'b0, 1'b1);
        idle(1);
        lookup(32'hBFC00010, 1'b1, 2'b00, 32'hBFC00100);
    endtask

    task automatic test_back_to_back;
        upd(32'hBFC00020, 32'hBFC00200, 1'b1, 1'b0);
        upd(32'hBFC00020, 32'hBFC00200, 1'b1, 1'b1);
        idle(1);
        lookup(32'hBFC00020, 1'b1, 2'b11, 32'hBFC00200);
        upd(32'hBFC00020, 32'h0, 1'b0, 1'b0);
        upd(32'hBFC00020, 32'h0, 1'b0, 1'b0);
        idle(1);
        lookup(32'hBFC00020, 1'b1, 2'b01, 32'hBFC00200);
    endtask

    task automatic test_alias;
        lookup(32'h80000010, 1'b0, 2'b00, 32'h0);
        upd(32'h80000010, 32'h80000200, 1'b1, 1'b0);
        idle(1);
        lookup(32'h80000010, 1'b1, 2'b10, 32'h80000200);
        lookup(32'hBFC00010, 1'b0, 2'b00, 32'h0);
    endtask

    task automatic test_hold_flush;
        lookup(32'h80000010, 1'b1, 2'b10, 32'h80000200);
        lookup_en    = 1'b0;
        lookup_valid = 1'b1;
        lookup_pc    = 32'hBFC00010;
        idle(2);
        checks++;
        if (pred_valid !== 1'b1 || pred_hit !== 1'b1 || pred_entry.count !== 2'b10 ||
            pred_entry.target !== 32'h80000200) begin
            errors++;
            $display("FAIL hold: v=%0b hit=%0b cnt=%b tgt=%h, want 1 1 10 80000200",
                     pred_valid, pred_hit, pred_entry.count, pred_entry.target);
        end
        lookup_en    = 1'b1;
        lookup_valid = 1'b0;
        idle(1);
        checks++;
        if (pred_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_valid: pred_valid=%0b, want 0", pred_valid);
        end
        lookup(32'h80000010, 1'b1, 2'b10, 32'h80000200);
        flush        = 1'b1;
        lookup_valid = 1'b1;
        lookup_pc    = 32'h80000010;
        idle(1);
        flush        = 1'b0;
        lookup_valid = 1'b0;
        checks++;
        if (pred_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_drop: pred_valid=%0b, want 0", pred_valid);
        end
    endtask

    task automatic test_perf;
        logic [31:0] exp_l;
        logic [31:0] exp_m;
`ifdef BPU_PERF_CNT_EN
        exp_l = 32'(n_look);
        exp_m = 32'(n_miss);
`else
        exp_l = 32'd0;
        exp_m = 32'd0;
`endif
        checks++;
        if (perf_lookup_cnt !== exp_l || perf_miss_cnt !== exp_m) begin
            errors++;
            $display("FAIL perf: lookup=%0d miss=%0d, want %0d %0d",
                     perf_lookup_cnt, perf_miss_cnt, exp_l, exp_m);
        end
    endtask

    task automatic test_reset_midflight;
        exp_t e;
        lookup_en    = 1'b1;
        lookup_valid = 1'b1;
        lookup_pc    = 32'h80000010;
        e.hit = 1'b1; e.taken = 1'b1; e.cnt = 2'b10;
        e.tgt = 32'h80000200; e.ty = 2'd2;
        sb.push_back(e);
        n_look++;
        update_valid                       = 1'b1;
        update_result                      = '0;
        update_result.valid                = 1'b1;
        update_result.success              = 1'b1;
        update_result.verify_entry.br_type = BR_CALL;
        update_result.taken                = 1'b1;
        update_result.target               = 32'hBFC00400;
        update_result.pc                   = 32'hBFC00040;
        @(posedge clk); #1;
        lookup_valid = 1'b0;
        update_valid = 1'b0;
        #1 resetn = 1'b0;
        #1;
        checks++;
        if (pred_valid !== 1'b0 || pred_hit !== 1'b0 || pred_entry !== '0) begin
            errors++;
            $display("FAIL async_reset: v=%0b hit=%0b entry=%h, want 0 0 0",
                     pred_valid, pred_hit, pred_entry);
        end
        @(posedge clk); #1;
        resetn = 1'b1;
        n_look = 0;
        n_miss = 0;
        test_perf();
        idle(1);
        lookup(32'hBFC00040, 1'b0, 2'b00, 32'h0);
        lookup(32'h80000010, 1'b0, 2'b00, 32'h0);
        lookup(32'hBFC00020, 1'b0, 2'b00, 32'h0);
        test_perf();
    endtask

    initial begin
        resetn        = 1'b0;
        flush         = 1'b0;
        lookup_en     = 1'b0;
        lookup_valid  = 1'b0;
        lookup_pc     = '0;
        update_valid  = 1'b0;
        update_result = '0;
        test_reset();
        test_miss();
        test_update_taken();
        test_saturation();
        test_back_to_back();
        test_alias();
        test_hold_flush();
        test_perf();
        test_reset_midflight();
        idle(2);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d responses missing, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
